mem_arbiter: RTL and testbench
==============================

Name:
mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-ported data memory (128 words, word-indexed address, write on posedge, combinational read).
- Lets the MEM-stage data port (requester 0) and a secondary master (requester 1: debug loader / fetch-miss path) share one memory instance.
- Uses round-robin arbitration, one registered access per grant, and a req/ack handshake.

Parameters:
- MEM_WORDS, 128: number of valid memory words. Addresses >= MEM_WORDS are out of range.
- FIRST_PORT, 0: port that wins the first arbitration after reset when both request.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- r0_req  input  1  port 0 access request; held high until r0_ack.
- r0_we  input  1  port 0 write enable (1 = write, 0 = read); stable while r0_req is high.
- r0_addr  input  32  port 0 word address; stable while r0_req is high.
- r0_wdata  input  32  port 0 write data.
- r0_ack  output  1  one-cycle completion pulse for port 0.
- r0_rdata  output  32  port 0 read data; valid with r0_ack and held until the next port-0 ack.
- r0_err  output  1  pulses with r0_ack when the access was out of range.
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata, r1_err: identical set for port 1.
- mem_read  output  1  to memory mem_read.
- mem_write  output  1  to memory mem_write.
- mem_address  output  32  to memory address.
- mem_wdata  output  32  to memory data_in.
- mem_rdata  input  32  from memory data_out (combinational).

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - mem_read, mem_write, r*_ack and r*_err = 0.
  - mem_address, mem_wdata, r0_rdata and r1_rdata = 0.
  - Priority pointer set so FIRST_PORT wins the next tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: grant the port not granted last; the pointer toggles only on an actual grant.
  - On a grant, latch owner, we, addr, wdata and the range flag (addr >= MEM_WORDS) into internal registers, then go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_address = latched addr, mem_wdata = latched wdata.
  - In range: mem_write = we, mem_read = ~we.
  - Out of range: both strobes 0, so memory is untouched.
  - A write commits at the posedge ending ACCESS.
  - On a read, the same edge captures mem_rdata into the owner's rdata register. An out-of-range read captures 0. A write leaves rdata unchanged.
  - Next state is RESP.
- RESP (one cycle):
  - Owner's ack = 1 and its err = range flag; the other port's ack/err = 0.
  - Strobes are 0; mem_address and mem_wdata hold their values.
  - Next state is always IDLE, so the requester has one cycle to drop req and is never re-granted on a stale req.
- Latency: request seen in IDLE at cycle N → ACCESS at N+1 → ack at N+2. Peak throughput is one access per 3 cycles.
- A req that is still high in the IDLE after its ack is treated as a new request (back-to-back access allowed).
- Requests arriving during ACCESS/RESP wait; they are never dropped.
- Only the granted port's input signals are sampled; changes on the other port's inputs have no effect.
- Asserting reset during ACCESS aborts the access before the edge: no write commits, no ack is issued, rdata returns to 0.
- Only the low bits of the 32-bit address that index MEM_WORDS are meaningful to the memory. The full 32-bit compare decides range.

Test Plan:
- Single read: memory preloaded mem[i]=i. r0 reads addr 5 → r0_ack 2 cycles after the request edge, r0_rdata = 5, r0_err = 0, exactly one cycle with mem_read = 1.
- Write then read: r1 writes 0xDEADBEEF to addr 10, then r1 reads addr 10 → second ack returns 0xDEADBEEF; r0_rdata unchanged.
- Contention: r0 and r1 both hold reads (addr 3, addr 7) from cycle 0.
  - Port 0 acks first with 3, then port 1 with 7.
  - With both held continuously, grants alternate 0,1,0,1.
- Out of range: r0 writes 0x55 to addr 200 → mem_write never asserts, r0_ack and r0_err pulse together, and a subsequent read of addr 72 (200 mod 128) returns 72.
- Reset mid-access: r0 write of 0x1234 to addr 4; assert reset during ACCESS → strobes drop immediately, no ack, and a later read of addr 4 returns 4.
- Back-to-back: r0 holds req for two reads (addr 1 then addr 2, address changed the cycle after the first ack) → two acks 3 cycles apart, returning 1 then 2.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer that lets two requesters share one single-ported data memory.
// Each grant runs IDLE -> ACCESS -> RESP, so one registered memory access completes every 3 cycles.
module mem_arbiter #(
  parameter int MEM_WORDS  = 128,
  parameter int FIRST_PORT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ack,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ack,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_ACCESS = 2'd1;
  localparam logic [1:0]  S_RESP   = 2'd2;
  localparam logic [31:0] LP_WORDS = 32'(MEM_WORDS);
  localparam logic        LP_FIRST = (FIRST_PORT != 0) ? 1'b1 : 1'b0;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic        r_owner;
  logic        r_we;
  logic        r_oor;
  logic        r_prio;

  logic        w_grant;
  logic        w_sel;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_oor;
  logic        w_start;
  logic        w_finish;
  logic        w_nxt_read;
  logic        w_nxt_write;
  logic        w_nxt_ack0;
  logic        w_nxt_ack1;
  logic        w_nxt_err0;
  logic        w_nxt_err1;
  logic [31:0] w_capture;

  // r_prio names the port that wins a tie; it flips away from whichever port was just granted
  always_comb begin
    w_grant = 1'b0;
    w_sel   = r_prio;
    if (r0_req && r1_req) begin
      w_grant = 1'b1;
      w_sel   = r_prio;
    end else if (r0_req) begin
      w_grant = 1'b1;
      w_sel   = 1'b0;
    end else if (r1_req) begin
      w_grant = 1'b1;
      w_sel   = 1'b1;
    end else begin
      w_grant = 1'b0;
      w_sel   = r_prio;
    end
  end

  assign w_sel_we    = w_sel ? r1_we    : r0_we;
  assign w_sel_addr  = w_sel ? r1_addr  : r0_addr;
  assign w_sel_wdata = w_sel ? r1_wdata : r0_wdata;
  assign w_sel_oor   = (w_sel_addr >= LP_WORDS);
  assign w_capture   = r_oor ? 32'd0 : mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_next_state = S_ACCESS;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ACCESS: w_next_state = S_RESP;
      S_RESP:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the current state
  always_comb begin
    w_start     = 1'b0;
    w_finish    = 1'b0;
    w_nxt_read  = 1'b0;
    w_nxt_write = 1'b0;
    w_nxt_ack0  = 1'b0;
    w_nxt_ack1  = 1'b0;
    w_nxt_err0  = 1'b0;
    w_nxt_err1  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start     = w_grant;
        w_nxt_read  = w_grant && !w_sel_we && !w_sel_oor;
        w_nxt_write = w_grant && w_sel_we && !w_sel_oor;
      end
      S_ACCESS: begin
        w_finish   = 1'b1;
        w_nxt_ack0 = !r_owner;
        w_nxt_ack1 = r_owner;
        w_nxt_err0 = !r_owner && r_oor;
        w_nxt_err1 = r_owner && r_oor;
      end
      default: begin
        w_start  = 1'b0;
        w_finish = 1'b0;
      end
    endcase
  end

  // Strobes are registered at the grant so they are high for exactly the ACCESS cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= 32'd0;
      mem_wdata   <= 32'd0;
      r0_ack      <= 1'b0;
      r1_ack      <= 1'b0;
      r0_err      <= 1'b0;
      r1_err      <= 1'b0;
      r0_rdata    <= 32'd0;
      r1_rdata    <= 32'd0;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_oor       <= 1'b0;
      r_prio      <= LP_FIRST;
    end else begin
      mem_read  <= w_nxt_read;
      mem_write <= w_nxt_write;
      r0_ack    <= w_nxt_ack0;
      r1_ack    <= w_nxt_ack1;
      r0_err    <= w_nxt_err0;
      r1_err    <= w_nxt_err1;
      if (w_start) begin
        r_owner     <= w_sel;
        r_we        <= w_sel_we;
        r_oor       <= w_sel_oor;
        mem_address <= w_sel_addr;
        mem_wdata   <= w_sel_wdata;
        r_prio      <= ~w_sel;
      end
      if (w_finish && !r_we) begin
        if (r_owner) begin
          r1_rdata <= w_capture;
        end else begin
          r0_rdata <= w_capture;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter, with a word-level memory model
// and a transaction-level reference of memory contents and per-port read data.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r0_req = 1'b0, r0_we = 1'b0;
  logic [31:0] r0_addr = 32'd0, r0_wdata = 32'd0;
  logic        r1_req = 1'b0, r1_we = 1'b0;
  logic [31:0] r1_addr = 32'd0, r1_wdata = 32'd0;
  logic        r0_ack, r0_err, r1_ack, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_wdata, mem_rdata;

  logic [31:0] mem [0:127];
  logic        preload = 1'b1;
  logic [31:0] ref_mem [0:127];
  logic [31:0] exp_rdata [0:1];
  int          n_vec = 0;
  int          n_err = 0;

  mem_arbiter #(.MEM_WORDS(128), .FIRST_PORT(0)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: write on posedge, combinational read, indexed by the low address bits
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'(i);
    end else if (mem_write) begin
      mem[mem_address[6:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_address[6:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d;
    end else begin
      r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d;
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? r0_ack : r1_ack;
  endfunction
  function automatic logic err_of(input int p);
    return (p == 0) ? r0_err : r1_err;
  endfunction
  function automatic logic [31:0] rd_of(input int p);
    return (p == 0) ? r0_rdata : r1_rdata;
  endfunction

  // One access from an idle arbiter; called on a negedge during an IDLE cycle
  task automatic do_acc(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    int lat = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic got = 1'b0;
    logic oor;
    logic [31:0] acc_addr = 32'hFFFF_FFFF;
    oor = (addr >= 32'd128);
    drive(p, 1'b1, we, addr, wd);
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      rd_cnt += int'(mem_read);
      wr_cnt += int'(mem_write);
      if (lat == 1) acc_addr = mem_address;
      if (ack_of(p)) got = 1'b1;
    end
    if (!we) begin
      exp_rdata[p] = oor ? 32'd0 : ref_mem[addr[6:0]];
    end else if (!oor) begin
      ref_mem[addr[6:0]] = wd;
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'd2);
    chk("err", 32'(err_of(p)), 32'(oor));
    chk("other_ack", 32'(ack_of(1 - p)), 32'd0);
    chk("rdata", rd_of(p), exp_rdata[p]);
    chk("other_rdata", rd_of(1 - p), exp_rdata[1 - p]);
    chk("read_strobes", 32'(rd_cnt), 32'(!we && !oor));
    chk("write_strobes", 32'(wr_cnt), 32'(we && !oor));
    chk("access_addr", acc_addr, addr);
    drive(p, 1'b0, we, addr, wd);
    @(negedge clk);
  endtask

  initial begin
    int seq[$];
    int tim[$];
    int t1, t2, acks, c;
    logic [31:0] ra;

    for (int i = 0; i < 128; i++) ref_mem[i] = 32'(i);
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_ack", {30'd0, r1_ack, r0_ack}, 32'd0);
    chk("rst_err", {30'd0, r1_err, r0_err}, 32'd0);
    chk("rst_r0_rdata", r0_rdata, 32'd0);
    chk("rst_r1_rdata", r1_rdata, 32'd0);
    reset = 1'b0;

    // Contention straight after reset: port 0 first, then strict alternation
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'd3, 32'd0);
    drive(1, 1'b1, 1'b0, 32'd7, 32'd0);
    c = 0;
    while (c < 14 && seq.size() < 4) begin
      @(negedge clk);
      c++;
      if (r0_ack) begin
        seq.push_back(0); tim.push_back(c);
        chk("cont_r0_rdata", r0_rdata, ref_mem[3]);
      end
      if (r1_ack) begin
        seq.push_back(1); tim.push_back(c);
        chk("cont_r1_rdata", r1_rdata, ref_mem[7]);
      end
    end
    drive(0, 1'b0, 1'b0, 32'd3, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd7, 32'd0);
    @(negedge clk);
    exp_rdata[0] = ref_mem[3];
    exp_rdata[1] = ref_mem[7];
    chk("cont_ack_count", 32'(seq.size()), 32'd4);
    for (int k = 0; k < seq.size(); k++) begin
      chk("cont_order", 32'(seq[k]), 32'(k % 2));
      if (k == 0) chk("cont_first_lat", 32'(tim[k]), 32'd2);
      else chk("cont_spacing", 32'(tim[k] - tim[k-1]), 32'd3);
    end

    do_acc(0, 1'b0, 32'd5, 32'd0);
    do_acc(1, 1'b1, 32'd10, 32'hDEAD_BEEF);
    do_acc(1, 1'b0, 32'd10, 32'd0);
    do_acc(0, 1'b1, 32'd200, 32'h0000_0055);
    do_acc(0, 1'b0, 32'd72, 32'd0);
    do_acc(1, 1'b0, 32'h8000_0001, 32'd0);

    // Back-to-back on port 0: req held, address changed the cycle after the first ack
    drive(0, 1'b1, 1'b0, 32'd1, 32'd0);
    t1 = -1; t2 = -1; c = 0;
    while (c < 20 && t2 < 0) begin
      @(negedge clk);
      c++;
      if (r0_ack && t1 < 0) begin
        t1 = c;
        chk("b2b_first", r0_rdata, ref_mem[1]);
      end else if (r0_ack) begin
        t2 = c;
        chk("b2b_second", r0_rdata, ref_mem[2]);
      end else if (t1 >= 0 && c == t1 + 1) begin
        r0_addr = 32'd2;
      end
    end
    drive(0, 1'b0, 1'b0, 32'd2, 32'd0);
    @(negedge clk);
    exp_rdata[0] = ref_mem[2];
    chk("b2b_first_lat", 32'(t1), 32'd2);
    chk("b2b_spacing", 32'(t2 - t1), 32'd3);

    // Reset during ACCESS aborts the write and clears read data
    drive(0, 1'b1, 1'b1, 32'd4, 32'h0000_1234);
    @(negedge clk);
    chk("abort_write_pending", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("abort_r0_rdata", r0_rdata, 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      acks += int'(r0_ack) + int'(r1_ack);
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    do_acc(0, 1'b0, 32'd4, 32'd0);

    // Randomized single-port traffic; the idle port's inputs wander and must be ignored
    for (int n = 0; n < 40; n++) begin
      int p;
      logic we;
      p  = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 159));
      drive(1 - p, 1'b0, 1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom));
      do_acc(p, we, ra, 32'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
